// File: rtl/ro_measure_pkg.sv
// rtl/ro_measure_pkg.sv - shared types and constants for the ring-oscillator measurement sequencer
//
// Contents:
//   meas_state_t      sequencer states
//   DEF_*             default widths and phase lengths
//   SRC_*             clock-source selector codes
package ro_measure_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CLEAR,
    GATE,
    SETTLE,
    CAPTURE,
    RESULT
  } meas_state_t;

  localparam int DEF_CFG_W      = 64;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_WIN_W      = 16;
  localparam int DEF_CLR_CYC    = 4;
  localparam int DEF_SETTLE_CYC = 3;

  localparam logic [2:0] SRC_DIV4 = 3'b000;
  localparam logic [2:0] SRC_RO3  = 3'b001;
  localparam logic [2:0] SRC_RO5  = 3'b010;
  localparam logic [2:0] SRC_RAW  = 3'b011;

endpackage

// File: rtl/cfg_serializer.sv
// rtl/cfg_serializer.sv - serial loader for the oscillator configuration shift chain
//
// Ports:
//   i_clk, i_rst_n   reference clock, synchronous active-low reset
//   i_start          one-cycle load request; captures i_cfg_word
//   i_cfg_word       configuration word, shifted out MSB first
//   o_done           high during the final clock-high phase; the owner leaves
//                    its shift state on the following edge
//   o_shift_clk      chain clock (low phase presents data, high phase clocks it)
//   o_shift_dta      chain data, stable across each low/high pair
module cfg_serializer
  import ro_measure_pkg::*;
#(
  parameter int CFG_W = DEF_CFG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CFG_W-1:0] i_cfg_word,
  output logic             o_done,
  output logic             o_shift_clk,
  output logic             o_shift_dta
);

  localparam int              BIT_W    = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CFG_W - 1);

  logic             r_active;
  logic             r_phase_b;
  logic [BIT_W-1:0] r_bit_idx;
  logic [CFG_W-1:0] r_shreg;
  logic             r_shift_clk;
  logic             r_shift_dta;
  logic             w_last;

  assign w_last      = r_active & r_phase_b & (r_bit_idx == LAST_BIT);
  assign o_done      = w_last;
  assign o_shift_clk = r_shift_clk;
  assign o_shift_dta = r_shift_dta;

  // The MSB goes straight onto shift_dta at load time, so the holding
  // register keeps the remaining bits pre-shifted and its top bit is always
  // the next bit to present.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_active    <= 1'b0;
      r_phase_b   <= 1'b0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_shift_clk <= 1'b0;
      r_shift_dta <= 1'b0;
    end else if (i_start) begin
      r_active    <= 1'b1;
      r_phase_b   <= 1'b0;
      r_bit_idx   <= '0;
      r_shreg     <= {i_cfg_word[CFG_W-2:0], 1'b0};
      r_shift_clk <= 1'b0;
      r_shift_dta <= i_cfg_word[CFG_W-1];
    end else if (r_active) begin
      if (!r_phase_b) begin
        r_shift_clk <= 1'b1;
        r_phase_b   <= 1'b1;
      end else begin
        r_shift_clk <= 1'b0;
        r_phase_b   <= 1'b0;
        if (w_last) begin
          r_active <= 1'b0;
        end else begin
          r_bit_idx   <= r_bit_idx + BIT_W'(1);
          r_shift_dta <= r_shreg[CFG_W-1];
          r_shreg     <= {r_shreg[CFG_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/ro_measure_ctrl.sv
// rtl/ro_measure_ctrl.sv - measurement sequencer for the ring-oscillator frequency counter
//
// Ports:
//   clk, rst_n                reference clock, synchronous active-low reset
//   start                     run request, accepted only when idle
//   cfg_word/src_sel/window   measurement setup, captured on acceptance
//   busy                      acceptance through result handshake
//   shift_clk/shift_dta       configuration shift chain
//   clk_source                clock selector code, updated on entry to CLEAR
//   cnt_clear/gate            event counter clear and enable window
//   cnt_value                 counter value, already in the clk domain
//   res_valid/res_ready       result handshake
//   result                    captured count, kept after the handshake
module ro_measure_ctrl
  import ro_measure_pkg::*;
#(
  parameter int CFG_W      = DEF_CFG_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int CLR_CYC    = DEF_CLR_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic [2:0]       src_sel,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic             shift_clk,
  output logic             shift_dta,
  output logic [2:0]       clk_source,
  output logic             cnt_clear,
  output logic             gate,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] result
);

  // Timed phases load (length - 1) and leave when the timer reads zero.
  localparam logic [WIN_W-1:0] CLR_LAST    = WIN_W'(CLR_CYC - 1);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);

  meas_state_t      r_state;
  meas_state_t      w_state_nxt;
  logic [WIN_W-1:0] r_tmr;
  logic [WIN_W-1:0] w_tmr_nxt;
  logic [2:0]       r_src;
  logic [WIN_W-1:0] r_window;
  logic             r_busy;
  logic             r_cnt_clear;
  logic             r_gate;
  logic             r_res_valid;
  logic [2:0]       r_clk_source;
  logic [CNT_W-1:0] r_result;
  logic             w_ser_start;
  logic             w_ser_done;

  cfg_serializer #(
    .CFG_W(CFG_W)
  ) u_cfg_serializer (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (w_ser_start),
    .i_cfg_word (cfg_word),
    .o_done     (w_ser_done),
    .o_shift_clk(shift_clk),
    .o_shift_dta(shift_dta)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_ser_start = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
          w_ser_start = 1'b1;
        end
      end
      SHIFT: begin
        if (w_ser_done) begin
          w_state_nxt = CLEAR;
          w_tmr_nxt   = CLR_LAST;
        end
      end
      CLEAR: begin
        if (r_tmr == '0) begin
          // A zero-length window skips the gate so the counter stays cleared.
          if (r_window == '0) begin
            w_state_nxt = SETTLE;
            w_tmr_nxt   = SETTLE_LAST;
          end else begin
            w_state_nxt = GATE;
            w_tmr_nxt   = r_window - WIN_W'(1);
          end
        end else begin
          w_tmr_nxt = r_tmr - WIN_W'(1);
        end
      end
      GATE: begin
        if (r_tmr == '0) begin
          w_state_nxt = SETTLE;
          w_tmr_nxt   = SETTLE_LAST;
        end else begin
          w_tmr_nxt = r_tmr - WIN_W'(1);
        end
      end
      SETTLE: begin
        if (r_tmr == '0) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_tmr_nxt = r_tmr - WIN_W'(1);
        end
      end
      CAPTURE: begin
        w_state_nxt = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each one lines up with
  // the state it belongs to without a decode stage on the output pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tmr        <= '0;
      r_src        <= '0;
      r_window     <= '0;
      r_busy       <= 1'b0;
      r_cnt_clear  <= 1'b0;
      r_gate       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_clk_source <= 3'b000;
      r_result     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_cnt_clear <= (w_state_nxt == CLEAR);
      r_gate      <= (w_state_nxt == GATE);
      r_res_valid <= (w_state_nxt == RESULT);
      if (w_ser_start) begin
        r_src    <= src_sel;
        r_window <= window;
      end
      // The selector switches only as CLEAR begins, so the counter is cleared
      // after the new source is already running.
      if ((w_state_nxt == CLEAR) && (r_state != CLEAR)) begin
        r_clk_source <= r_src;
      end
      if (r_state == CAPTURE) begin
        r_result <= cnt_value;
      end
    end
  end

  assign busy       = r_busy;
  assign cnt_clear  = r_cnt_clear;
  assign gate       = r_gate;
  assign res_valid  = r_res_valid;
  assign clk_source = r_clk_source;
  assign result     = r_result;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb/tb_ro_measure_ctrl.sv - self-checking bench for ro_measure_ctrl
module tb_ro_measure_ctrl;
  import ro_measure_pkg::*;

  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_word = '0;
  logic [2:0]  src_sel = '0;
  logic [15:0] window = '0;
  logic        busy, shift_clk, shift_dta, cnt_clear, gate, res_valid;
  logic [2:0]  clk_source;
  logic [31:0] cnt_value = '0;
  logic        res_ready = 1'b0;
  logic [31:0] result;

  int          n_pass = 0;
  int          n_total = 0;
  logic [2:0]  m_src = 3'b000;
  logic [31:0] m_result = '0;

  ro_measure_ctrl #(.CFG_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_word(cfg_word), .src_sel(src_sel),
    .window(window), .busy(busy), .shift_clk(shift_clk), .shift_dta(shift_dta),
    .clk_source(clk_source), .cnt_clear(cnt_clear), .gate(gate), .cnt_value(cnt_value),
    .res_valid(res_valid), .res_ready(res_ready), .result(result)
  );

  always #5 clk = ~clk;

  // Event counter of the datapath: cleared by cnt_clear, one event per gated cycle.
  initial cnt_value = $urandom;
  always @(negedge clk) begin
    if (cnt_clear) cnt_value = '0;
    else if (gate) cnt_value = cnt_value + 32'd1;
  end

  // Runs one measurement starting at a falling edge. Expected waveforms come
  // from the timeline: 2 cycles per chain bit, 4 clear cycles, win gate
  // cycles, 3 settle cycles, 1 capture cycle, then the result waits on ready.
  task automatic run_measure(input logic [7:0] word, input logic [2:0] src, input int win,
                             input int hold, input bit poke, input bit start_at_hs,
                             input int abort_at);
    int n2, t_valid, t_end;
    logic exp_clk, exp_clear, exp_gate, exp_valid;
    logic [2:0]  exp_src;
    logic [31:0] exp_res;
    n2      = 2 * CW;
    t_valid = n2 + 4 + win + 3 + 1;
    t_end   = t_valid + hold;
    start = 1'b1; cfg_word = word; src_sel = src; window = 16'(win);
    @(negedge clk);
    start = 1'b0; cfg_word = 8'($urandom); src_sel = 3'($urandom); window = 16'($urandom);
    for (int t = 0; t <= t_end; t++) begin
      exp_clk   = (t < n2) && (t % 2 == 1);
      exp_clear = (t >= n2) && (t < n2 + 4);
      exp_gate  = (t >= n2 + 4) && (t < n2 + 4 + win);
      exp_valid = (t >= t_valid);
      exp_src   = (t >= n2) ? src : m_src;
      exp_res   = (t >= t_valid) ? 32'(win) : m_result;
      n_total++; if (busy !== 1'b1) $display("FAIL busy t=%0d got %b want 1", t, busy); else n_pass++;
      n_total++; if (shift_clk !== exp_clk) $display("FAIL shift_clk t=%0d got %b want %b", t, shift_clk, exp_clk); else n_pass++;
      if (t < n2) begin
        n_total++;
        if (shift_dta !== word[CW-1-t/2]) $display("FAIL shift_dta t=%0d got %b want %b", t, shift_dta, word[CW-1-t/2]);
        else n_pass++;
      end
      n_total++; if (cnt_clear !== exp_clear) $display("FAIL cnt_clear t=%0d got %b want %b", t, cnt_clear, exp_clear); else n_pass++;
      n_total++; if (gate !== exp_gate) $display("FAIL gate t=%0d got %b want %b", t, gate, exp_gate); else n_pass++;
      n_total++; if (res_valid !== exp_valid) $display("FAIL res_valid t=%0d got %b want %b", t, res_valid, exp_valid); else n_pass++;
      n_total++; if (clk_source !== exp_src) $display("FAIL clk_source t=%0d got %0d want %0d", t, clk_source, exp_src); else n_pass++;
      n_total++; if (result !== exp_res) $display("FAIL result t=%0d got %0d want %0d", t, result, exp_res); else n_pass++;
      if (t == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, shift_clk, shift_dta, cnt_clear, gate, res_valid, clk_source, result} !== 41'd0)
          $display("FAIL abort_reset got %h want 0",
                   {busy, shift_clk, shift_dta, cnt_clear, gate, res_valid, clk_source, result});
        else n_pass++;
        rst_n = 1'b1; m_src = 3'b000; m_result = '0;
        return;
      end
      res_ready = (t < t_valid) ? 1'($urandom_range(0, 1)) : (t == t_end);
      start = (t == t_end) ? start_at_hs
                           : (poke && ((t == t_valid + 1) || ($urandom_range(0, 3) == 0)));
      @(negedge clk);
    end
    n_total++; if (res_valid !== 1'b0) $display("FAIL hs_valid got %b want 0", res_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL hs_busy got %b want 0", busy); else n_pass++;
    n_total++; if (result !== 32'(win)) $display("FAIL hs_result got %0d want %0d", result, win); else n_pass++;
    n_total++; if (clk_source !== src) $display("FAIL hs_src got %0d want %0d", clk_source, src); else n_pass++;
    start = 1'b0; res_ready = 1'b0; m_src = src; m_result = 32'(win);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n_total++;
    if ({busy, shift_clk, shift_dta, cnt_clear, gate, res_valid, clk_source, result} !== 41'd0)
      $display("FAIL reset_state got %h want 0",
               {busy, shift_clk, shift_dta, cnt_clear, gate, res_valid, clk_source, result});
    else n_pass++;
    start = 1'b0; rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else n_pass++;
    end
  endtask

  task automatic test_shift_and_gate;
    run_measure(8'hA5, SRC_RO5, 100, 20, 1'b1, 1'b0, -1);
  endtask

  task automatic test_window_edges;
    run_measure(8'($urandom), SRC_RO3, 0, 2, 1'b0, 1'b0, -1);
    run_measure(8'($urandom), SRC_DIV4, 1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_gate;
    run_measure(8'($urandom), SRC_RAW, 100, 0, 1'b0, 1'b0, 2 * CW + 4 + 49);
    run_measure(8'($urandom), SRC_RO3, 10, 3, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    run_measure(8'($urandom), SRC_RO5, 5, 1, 1'b0, 1'b1, -1);
    run_measure(8'($urandom), SRC_RAW, 7, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random;
    int gap;
    for (int i = 0; i < 6; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        res_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL gap_busy got %b want 0", busy); else n_pass++;
      end
      res_ready = 1'b0;
      run_measure(8'($urandom), 3'($urandom), $urandom_range(0, 60), $urandom_range(0, 5),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset;
    test_shift_and_gate;
    test_window_edges;
    test_reset_mid_gate;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ro_measure_ctrl.md
Name: ro_measure_ctrl

Overview:
Measurement sequencer for the ring-oscillator frequency-counter datapath.
- On a start command it serially loads the oscillator configuration word into the 64-bit shift chain over shift_clk/shift_dta.
- It then selects the clock source, clears the event counter and opens a gate for a programmed number of reference-clock cycles.
- It captures the settled count and presents it through a valid/ready result port.
- It sits between the top-level command/IO logic and the oscillator/counter datapath.

Parameters:
- CFG_W, 64, length of the oscillator shift chain / configuration word in bits
- CNT_W, 32, width of the event counter value and of the result
- WIN_W, 16, width of the gate-window length field
- CLR_CYC, 4, cycles cnt_clear is held asserted before gating
- SETTLE_CYC, 3, cycles waited after gate closes before sampling cnt_value (synchronizer latency)

Ports:
- clk  in  1  reference clock; all logic on its rising edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  one-cycle request to run a measurement; accepted only in IDLE
- cfg_word  in  CFG_W  oscillator configuration, sampled when start is accepted
- src_sel  in  3  clock-source code for the selector, sampled when start is accepted
- window  in  WIN_W  gate length in clk cycles, sampled when start is accepted
- busy  out  1  high from start acceptance until result handshake completes
- shift_clk  out  1  shift-chain clock
- shift_dta  out  1  shift-chain serial data
- clk_source  out  3  selector code to datapath
- cnt_clear  out  1  counter clear, active high
- gate  out  1  counter enable window
- cnt_value  in  CNT_W  counter value, already synchronized into clk domain
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- result  out  CNT_W  captured count

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-operation:
  - state returns to IDLE.
  - busy, shift_clk, shift_dta, cnt_clear, gate and res_valid are 0.
  - clk_source is 3'b000; result is 0.
- FSM states and transitions:
  - IDLE -> SHIFT on start. Latch cfg_word, src_sel and window; busy=1 the next cycle.
  - SHIFT: 2 cycles per bit, MSB first, so cfg_word[0] lands in chain bit 0 after CFG_W bits.
    - Phase A: shift_dta = current bit, shift_clk=0.
    - Phase B: shift_clk=1, shift_dta held.
    - After the last phase B the next state is CLEAR with shift_clk=0. Total time is exactly 2*CFG_W cycles.
  - CLEAR: clk_source driven with the latched src_sel from this state onward. cnt_clear=1 for CLR_CYC cycles, then -> GATE.
  - GATE: gate=1 for exactly window cycles, then -> SETTLE.
    - window=0 skips GATE entirely; gate never rises and the expected result is 0.
  - SETTLE: gate=0 for SETTLE_CYC cycles, then -> CAPTURE.
  - CAPTURE: result <= cnt_value. res_valid=1 from the next cycle; -> RESULT.
  - RESULT: res_valid and result held until res_ready=1 at a clk edge.
    - On that edge: res_valid=0, busy=0, -> IDLE. result keeps its value.
    - res_ready while res_valid=0 is ignored.
- start while busy is ignored, with no queuing. start in the same cycle as the RESULT handshake is also ignored; it is accepted from IDLE on a later cycle.
- clk_source holds its last value after returning to IDLE (reset only clears it).
- The bit index and window counters are internal, with no wrap-around beyond their terminal counts. The window counter is WIN_W bits, so the maximum gate is 2^WIN_W-1 cycles.
- All outputs are registered (no combinational path from inputs to outputs).

Decomposition:
- Package ro_measure_pkg holds:
  - the state enum (IDLE, SHIFT, CLEAR, GATE, SETTLE, CAPTURE, RESULT)
  - default CLR_CYC and SETTLE_CYC constants
  - source-code constants: SRC_DIV4=3'b000, SRC_RO3=3'b001, SRC_RO5=3'b010, SRC_RAW=3'b011
- One sub-module, cfg_serializer, owns the CFG_W-bit load register, bit counter and shift_clk/shift_dta phase generation. It has a start/done handshake to the main FSM.

Test Plan:
- CFG_W=8, cfg_word=8'hA5, start -> shift_clk has 8 rising edges. shift_dta at each rising edge is 1,0,1,0,0,1,0,1. SHIFT lasts 16 cycles.
- src_sel=3'b010, window=100, cnt_value model increments while gate=1 -> gate high exactly 100 cycles, cnt_clear high 4 cycles before it. result=100 and res_valid=1 exactly SETTLE_CYC+1 cycles after gate falls.
- window=0 -> gate never asserts; result=0 and res_valid=1.
- res_ready held 0 for 20 cycles -> res_valid and result stable, busy=1. A start pulse during this time is ignored. res_ready=1 -> res_valid, busy drop next cycle.
- rst_n=0 for one cycle during GATE (cycle 50 of 100) -> next cycle all outputs at reset values and FSM in IDLE. A new start then runs a full sequence.
- Back-to-back: start the cycle after the handshake with src_sel=3'b011 -> accepted. clk_source changes to 3'b011 only when CLEAR is entered.
